// File: rtl/core_pkg.sv
// Shared definitions for the multicycle core: opcodes, sequencer states,
// instruction-field offsets and immediate sign extension.
package core_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_ADDI = 4'd5;
  localparam logic [3:0] OP_LD   = 4'd6;
  localparam logic [3:0] OP_ST   = 4'd7;
  localparam logic [3:0] OP_BEQ  = 4'd8;
  localparam logic [3:0] OP_BNE  = 4'd9;
  localparam logic [3:0] OP_JMP  = 4'd10;
  localparam logic [3:0] OP_HALT = 4'd15;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  function automatic int imm_width(input int instr_w, input int rf_addr_w);
    return instr_w - 4 - 2 * rf_addr_w;
  endfunction

  function automatic int rs_lsb(input int instr_w, input int rf_addr_w);
    return instr_w - 4 - rf_addr_w;
  endfunction

  function automatic int rt_lsb(input int instr_w, input int rf_addr_w);
    return instr_w - 4 - 2 * rf_addr_w;
  endfunction

  // Replicates bit width-1 of val across the upper bits of a 32-bit word.
  function automatic logic [31:0] sext(input logic [31:0] val, input int width);
    logic signed [31:0] shifted;
    shifted = $signed(val << (32 - width));
    return shifted >>> (32 - width);
  endfunction

endpackage

// File: rtl/core_alu.sv
// Combinational ALU for the multicycle core; ovf reports signed overflow
// for ADD and SUB only.
module core_alu
  import core_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              ovf
);

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (op)
      OP_ADD: begin
        result = a + b;
        ovf    = (a[DATA_W-1] == b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
      end
      OP_SUB: begin
        result = a - b;
        ovf    = (a[DATA_W-1] != b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_core.sv
// Multicycle processor core: sequencer, register file, decode and PC logic,
// with req/ack instruction and data memory ports that tolerate wait states.
module multicycle_core
  import core_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int RF_ADDR_W = 2,
  parameter int INSTR_W   = 16,
  parameter int PC_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DATA_W-1:0]  dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic               dmem_ack,
  input  logic [DATA_W-1:0]  dmem_rdata,
  output logic               ovf,
  output logic               halted,
  output logic               retired,
  output logic [PC_W-1:0]    dbg_pc
);

  localparam int IMM_W  = imm_width(INSTR_W, RF_ADDR_W);
  localparam int RS_LSB = rs_lsb(INSTR_W, RF_ADDR_W);
  localparam int RT_LSB = rt_lsb(INSTR_W, RF_ADDR_W);
  localparam int NREG   = 2 ** RF_ADDR_W;

  state_t             state;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] ir;
  logic [DATA_W-1:0]  a, b, result;
  logic [DATA_W-1:0]  rf [NREG];

  logic [3:0]           opcode, alu_op;
  logic [RF_ADDR_W-1:0] rs, rt, rd, dest;
  logic [IMM_W-1:0]     imm;
  logic [DATA_W-1:0]    imm_sx, alu_b, alu_res;
  logic [PC_W-1:0]      pc_off, jmp_tgt;
  logic                 alu_ovf, is_rtype, take_branch;

  assign opcode   = ir[INSTR_W-1 -: 4];
  assign rs       = ir[RS_LSB +: RF_ADDR_W];
  assign rt       = ir[RT_LSB +: RF_ADDR_W];
  assign imm      = ir[IMM_W-1:0];
  assign rd       = imm[IMM_W-1 -: RF_ADDR_W];
  assign imm_sx   = DATA_W'(sext(32'(imm), IMM_W));
  assign pc_off   = PC_W'(sext(32'(imm), IMM_W));
  assign jmp_tgt  = PC_W'(imm);

  // ADDI and the load/store address both reuse the ALU adder with the immediate.
  assign is_rtype    = (opcode <= OP_XOR);
  assign alu_op      = is_rtype ? opcode : OP_ADD;
  assign alu_b       = is_rtype ? b : imm_sx;
  assign dest        = is_rtype ? rd : rt;
  assign take_branch = (opcode == OP_BEQ) ? (a == b) : (a != b);

  assign imem_addr = pc;
  assign dbg_pc    = pc;

  core_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (alu_op),
    .a      (a),
    .b      (alu_b),
    .result (alu_res),
    .ovf    (alu_ovf)
  );

  // The fetch request rises as FETCH is entered, except straight out of reset
  // where FETCH spends one idle cycle raising it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_FETCH;
      pc         <= '0;
      ir         <= '0;
      a          <= '0;
      b          <= '0;
      result     <= '0;
      ovf        <= 1'b0;
      halted     <= 1'b0;
      retired    <= 1'b0;
      imem_req   <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      retired <= 1'b0;
      case (state)
        S_FETCH: begin
          if (!imem_req) begin
            imem_req <= 1'b1;
          end else if (imem_ack) begin
            ir       <= imem_rdata;
            pc       <= pc + 1'b1;
            imem_req <= 1'b0;
            state    <= S_DECODE;
          end
        end
        S_DECODE: begin
          a     <= rf[rs];
          b     <= rf[rt];
          state <= S_EXEC;
        end
        S_EXEC: begin
          case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI: begin
              result <= alu_res;
              if (opcode == OP_ADD || opcode == OP_SUB || opcode == OP_ADDI) ovf <= alu_ovf;
              state <= S_WB;
            end
            OP_LD, OP_ST: begin
              dmem_addr  <= alu_res;
              dmem_we    <= (opcode == OP_ST);
              dmem_wdata <= b;
              dmem_req   <= 1'b1;
              state      <= S_MEM;
            end
            OP_BEQ, OP_BNE: begin
              if (take_branch) pc <= pc + pc_off;
              retired  <= 1'b1;
              imem_req <= 1'b1;
              state    <= S_FETCH;
            end
            OP_JMP: begin
              pc       <= jmp_tgt;
              retired  <= 1'b1;
              imem_req <= 1'b1;
              state    <= S_FETCH;
            end
            OP_HALT: begin
              halted <= 1'b1;
              state  <= S_HALT;
            end
            default: begin
              retired  <= 1'b1;
              imem_req <= 1'b1;
              state    <= S_FETCH;
            end
          endcase
        end
        S_MEM: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            if (dmem_we) begin
              retired  <= 1'b1;
              imem_req <= 1'b1;
              state    <= S_FETCH;
            end else begin
              result <= dmem_rdata;
              state  <= S_WB;
            end
          end
        end
        S_WB: begin
          rf[dest] <= result;
          retired  <= 1'b1;
          imem_req <= 1'b1;
          state    <= S_FETCH;
        end
        S_HALT: begin
          halted <= 1'b1;
        end
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule
